add_sub_seq: RTL and testbench

Multi-cycle, parametrised signed add/subtract unit computing S = A + (-1)^k·B on N-bit two's-complement operands with an (N+1)-bit exact result. Processes W bits per cycle, holding the carry in a register, so wide datapaths close timing with a narrow adder. Sits between an operand producer and a result consumer, each joined by a valid/ready handshake. Also reports carry-out and N-bit signed overflow.

---
 rtl/add_sub_pkg.sv | 22 ++
 rtl/add_sub_chunk.sv | 38 +++
 rtl/add_sub_seq.sv | 155 +++++++++++++++
 tb/tb_add_sub_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// add_sub_pkg: shared types and helpers for the sequential add/subtract unit.
//   state_t            FSM state encoding (IDLE, RUN, DONE)
//   nch(n, w)          number of W-bit chunks in an N-bit operand
//   ADD_SUB_CHECK_CFG  elaboration-time guard on the N/W configuration
`define ADD_SUB_CHECK_CFG(n_, w_) \
  if ((w_) < 1 || (w_) > (n_) || (n_) < 2 || ((n_) % (w_)) != 0) begin : g_bad_cfg \
    $error("add_sub_seq: illegal configuration, need N>=2, 1<=W<=N, N%%W==0"); \
  end

package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nch(input int n, input int w);
    return n / w;
  endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// add_sub_chunk: combinational W-bit ripple adder slice.
//   a, b   W-bit operand slices
//   inv    invert b before adding (subtract)
//   cin    carry into bit 0
//   sum    W-bit slice sum
//   cout   carry out of bit W-1
//   c_msb  carry into bit W-1 (signed-overflow detection on the top chunk)
module add_sub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         inv,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W-1:0] b_eff_s;
  logic [W:0]   c_s;

  // Bit-serial ripple through the slice.
  always_comb begin
    b_eff_s = b ^ {W{inv}};
    c_s     = '0;
    sum     = '0;
    c_s[0]  = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ b_eff_s[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b_eff_s[i]) | (c_s[i] & (a[i] ^ b_eff_s[i]));
    end
  end

  assign cout  = c_s[W];
  assign c_msb = c_s[W-1];

endmodule

// File: rtl/add_sub_seq.sv
// add_sub_seq: multi-cycle signed add/subtract, S = A + (-1)^k * B, with an
// exact (N+1)-bit result, computed W bits per cycle through one narrow adder.
//   clk, rst_n            clock; asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, k sampled on accept)
//   a, b                  N-bit signed operands; k = 0 add, 1 subtract
//   out_valid / out_ready result handshake
//   s                     (N+1)-bit result
//   cout                  carry out of bit N-1 of A + (B ^ k) + k
//   ovf                   N-bit signed overflow
module add_sub_seq
  import add_sub_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         k,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   s,
  output logic         cout,
  output logic         ovf
);

  `ADD_SUB_CHECK_CFG(N, W)

  localparam int NCH = nch(N, W);
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  state_t        state_r;
  state_t        next_state_s;
  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic          k_r;
  logic          carry_r;
  logic [IW-1:0] idx_r;
  logic [N:0]    s_r;
  logic          cout_r;
  logic          ovf_r;
  logic          in_ready_r;
  logic          out_valid_r;

  logic [W-1:0]  a_chunk_s;
  logic [W-1:0]  b_chunk_s;
  logic [W-1:0]  sum_s;
  logic          c_s;
  logic          c_msb_s;
  logic          last_s;
  logic          b_msb_eff_s;

  assign a_chunk_s   = a_r[int'(idx_r) * W +: W];
  assign b_chunk_s   = b_r[int'(idx_r) * W +: W];
  assign last_s      = (idx_r == LAST_IDX);
  assign b_msb_eff_s = b_r[N-1] ^ k_r;

  add_sub_chunk #(.W(W)) u_chunk (
    .a     (a_chunk_s),
    .b     (b_chunk_s),
    .inv   (k_r),
    .cin   (carry_r),
    .sum   (sum_s),
    .cout  (c_s),
    .c_msb (c_msb_s)
  );

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) next_state_s = RUN;
        else          next_state_s = IDLE;
      end
      RUN: begin
        if (last_s) next_state_s = DONE;
        else        next_state_s = RUN;
      end
      DONE: begin
        if (out_ready) next_state_s = IDLE;
        else           next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register and registered handshake flags (decoded from next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == IDLE);
      out_valid_r <= (next_state_s == DONE);
    end
  end

  // Operand capture, per-chunk accumulation and final sign/flag computation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      k_r     <= 1'b0;
      carry_r <= 1'b0;
      idx_r   <= '0;
      s_r     <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            k_r     <= k;
            carry_r <= k;  // carry-in of 1 completes two's-complement negate
            idx_r   <= '0;
            s_r     <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
          end
        end
        RUN: begin
          s_r[int'(idx_r) * W +: W] <= sum_s;
          carry_r                   <= c_s;
          if (last_s) begin
            idx_r  <= '0;
            // Sign-extension bit of the exact result.
            s_r[N] <= a_r[N-1] ^ b_msb_eff_s ^ c_s;
            cout_r <= c_s;
            ovf_r  <= c_s ^ c_msb_s;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign s         = s_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_add_sub_seq.sv
// tb_add_sub_seq: self-checking bench for add_sub_seq. One N=8/W=2 instance
// for directed, backpressure, reset and back-to-back scenarios, plus three
// N=32 instances (W = 1, 8, 32) for the randomized configuration sweep.
module tb_add_sub_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  // N=8, W=2 instance
  logic       iv8, ir8, ov8, or8, k8, co8, of8;
  logic [7:0] a8, b8;
  logic [8:0] s8;

  add_sub_seq #(.N(8), .W(2)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a         (a8),
    .b         (b8),
    .k         (k8),
    .out_valid (ov8),
    .out_ready (or8),
    .s         (s8),
    .cout      (co8),
    .ovf       (of8)
  );

  // N=32 sweep instances
  logic        iv32 [3];
  logic        ir32 [3];
  logic        ov32 [3];
  logic        or32 [3];
  logic        co32 [3];
  logic        of32 [3];
  logic [32:0] s32  [3];
  logic [31:0] a32, b32;
  logic        k32;

  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    add_sub_seq #(.N(32), .W(gi == 0 ? 1 : (gi == 1 ? 8 : 32))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv32[gi]),
      .in_ready  (ir32[gi]),
      .a         (a32),
      .b         (b32),
      .k         (k32),
      .out_valid (ov32[gi]),
      .out_ready (or32[gi]),
      .s         (s32[gi]),
      .cout      (co32[gi]),
      .ovf       (of32[gi])
    );
  end

  // Reference: exact signed arithmetic on sign-extended values.
  function automatic void ref_op(input int n, input longint unsigned ua,
                                 input longint unsigned ub, input bit kk,
                                 output logic [32:0] rs, output bit rc, output bit ro);
    longint unsigned m;
    longint unsigned mask;
    longint          sa, sb, sum;
    m    = 64'd1 << n;
    mask = (m << 1) - 64'd1;
    sa   = (ua >= m / 2) ? longint'(ua) - longint'(m) : longint'(ua);
    sb   = (ub >= m / 2) ? longint'(ub) - longint'(m) : longint'(ub);
    sum  = kk ? sa - sb : sa + sb;
    rs   = 33'(longint'(sum) & longint'(mask));
    rc   = kk ? (ua >= ub) : ((ua + ub) >= m);
    ro   = (sum >= longint'(m / 2)) || (sum < -longint'(m / 2));
  endfunction

  function automatic logic [31:0] pick32();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0:       v = 32'h0000_0000;
      1:       v = 32'h7FFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'hFFFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Drive one operation on the 8-bit DUT and return what it produced.
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ik,
                     input int hold, output logic [8:0] rs, output logic rc,
                     output logic ro, output int lat, output bit to);
    int guard;
    to    = 1'b0;
    guard = 0;
    while (!ir8 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!ir8) to = 1'b1;
    a8 = ia; b8 = ib; k8 = ik; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    a8  = 8'($urandom); b8 = 8'($urandom); k8 = 1'($urandom);
    lat = 0;
    while (!ov8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!ov8) to = 1'b1;
    rs = s8; rc = co8; ro = of8;
    repeat (hold) @(negedge clk);
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv8 = 1'b0; or8 = 1'b0; a8 = 8'h00; b8 = 8'h00; k8 = 1'b0;
    a32 = 32'h0; b32 = 32'h0; k32 = 1'b0;
    for (int d = 0; d < 3; d++) begin
      iv32[d] = 1'b0;
      or32[d] = 1'b0;
    end
    #12;
    n_vec++;
    if ({ir8, ov8, s8, co8, of8} !== {1'b1, 1'b0, 9'h000, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset8: got rdy=%b vld=%b s=%h c=%b o=%b want 1 0 000 0 0",
               ir8, ov8, s8, co8, of8);
    end
    for (int d = 0; d < 3; d++) begin
      n_vec++;
      if ({ir32[d], ov32[d], s32[d]} !== {1'b1, 1'b0, 33'h0}) begin
        n_err++;
        $display("FAIL reset32[%0d]: got rdy=%b vld=%b s=%h want 1 0 0", d, ir32[d], ov32[d], s32[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] ta [4] = '{8'h7F, 8'h80, 8'h05, 8'hFF};
    logic [7:0] tb [4] = '{8'h01, 8'h01, 8'h03, 8'hFF};
    logic       tk [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [8:0] es [4] = '{9'h080, 9'h17F, 9'h002, 9'h1FE};
    logic       ec [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic       eo [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [8:0] rs;
    logic       rc, ro;
    int         lat;
    bit         to;
    for (int i = 0; i < 4; i++) begin
      op8(ta[i], tb[i], tk[i], 0, rs, rc, ro, lat, to);
      n_vec++;
      if (to || {rs, rc, ro} !== {es[i], ec[i], eo[i]}) begin
        n_err++;
        $display("FAIL directed[%0d]: got s=%h c=%b o=%b to=%b want s=%h c=%b o=%b",
                 i, rs, rc, ro, to, es[i], ec[i], eo[i]);
      end
      n_vec++;
      if (lat !== 4) begin
        n_err++;
        $display("FAIL latency8[%0d]: got %0d want 4", i, lat);
      end
      n_vec++;
      if (ir8 !== 1'b1) begin
        n_err++;
        $display("FAIL ready_after[%0d]: got %b want 1", i, ir8);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] es;
    bit          ec, eo;
    int          guard;
    ref_op(8, 64'h3C, 64'h5A, 1'b1, es, ec, eo);
    a8 = 8'h3C; b8 = 8'h5A; k8 = 1'b1; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    guard = 0;
    while (!ov8 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    for (int c = 0; c < 10; c++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); k8 = 1'($urandom); iv8 = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({ov8, ir8, s8, co8, of8} !== {1'b1, 1'b0, es[8:0], ec, eo}) begin
        n_err++;
        $display("FAIL backpressure[%0d]: got vld=%b rdy=%b s=%h c=%b o=%b want 1 0 %h %b %b",
                 c, ov8, ir8, s8, co8, of8, es[8:0], ec, eo);
      end
    end
    iv8 = 1'b0; or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    n_vec++;
    if ({ir8, ov8} !== 2'b10) begin
      n_err++;
      $display("FAIL bp_release: got rdy=%b vld=%b want 1 0", ir8, ov8);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [8:0] rs;
    logic       rc, ro;
    int         lat;
    bit         to;
    a8 = 8'h55; b8 = 8'h22; k8 = 1'b0; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ov8, ir8, s8, co8, of8} !== {1'b0, 1'b1, 9'h000, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid: got vld=%b rdy=%b s=%h c=%b o=%b want 0 1 000 0 0",
               ov8, ir8, s8, co8, of8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op8(8'h10, 8'h20, 1'b0, 1, rs, rc, ro, lat, to);
    n_vec++;
    if (to || {rs, rc, ro} !== {9'h030, 1'b0, 1'b0} || lat !== 4) begin
      n_err++;
      $display("FAIL after_reset: got s=%h c=%b o=%b lat=%0d to=%b want 030 0 0 4",
               rs, rc, ro, lat, to);
    end
  endtask

  task automatic test_random8();
    logic [7:0]  ra, rb;
    logic        rk;
    logic [8:0]  rs;
    logic        rc, ro;
    logic [32:0] es;
    bit          ec, eo, to;
    int          lat;
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rk = 1'($urandom);
      ref_op(8, 64'(ra), 64'(rb), rk, es, ec, eo);
      op8(ra, rb, rk, $urandom_range(0, 3), rs, rc, ro, lat, to);
      n_vec++;
      if (to || lat !== 4 || {rs, rc, ro} !== {es[8:0], ec, eo}) begin
        n_err++;
        $display("FAIL random8[%0d] a=%h b=%h k=%b: got s=%h c=%b o=%b lat=%0d want s=%h c=%b o=%b lat=4",
                 i, ra, rb, rk, rs, rc, ro, lat, es[8:0], ec, eo);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] es;
    bit          ec, eo, seen;
    int          cyc, guard;
    iv8 = 1'b1; or8 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      guard = 0;
      while (!ir8 && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      a8 = 8'($urandom); b8 = 8'($urandom); k8 = 1'($urandom);
      ref_op(8, 64'(a8), 64'(b8), k8, es, ec, eo);
      cyc  = 0;
      seen = 1'b0;
      do begin
        @(negedge clk);
        cyc++;
        if (ov8 && !seen) begin
          seen = 1'b1;
          n_vec++;
          if ({s8, co8, of8} !== {es[8:0], ec, eo}) begin
            n_err++;
            $display("FAIL b2b_result[%0d]: got s=%h c=%b o=%b want s=%h c=%b o=%b",
                     i, s8, co8, of8, es[8:0], ec, eo);
          end
        end
      end while (!ir8 && cyc < 50);
      if (i == 5) iv8 = 1'b0;
      n_vec++;
      if (cyc !== 6 || !seen) begin
        n_err++;
        $display("FAIL b2b_period[%0d]: got %0d cycles seen=%b want 6 seen=1", i, cyc, seen);
      end
    end
    iv8 = 1'b0; or8 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep();
    logic [32:0] es;
    bit          ec, eo, to;
    int          lat, guard, want_lat;
    logic [31:0] ra, rb;
    logic        rk;
    for (int d = 0; d < 3; d++) begin
      want_lat = (d == 0) ? 32 : ((d == 1) ? 4 : 1);
      for (int i = 0; i < 1000; i++) begin
        to    = 1'b0;
        guard = 0;
        while (!ir32[d] && guard < 100) begin
          @(negedge clk);
          guard++;
        end
        if (!ir32[d]) to = 1'b1;
        ra = pick32(); rb = pick32(); rk = 1'($urandom);
        ref_op(32, 64'(ra), 64'(rb), rk, es, ec, eo);
        a32 = ra; b32 = rb; k32 = rk; iv32[d] = 1'b1;
        @(negedge clk);
        iv32[d] = 1'b0;
        a32 = $urandom; b32 = $urandom; k32 = 1'($urandom);
        lat = 0;
        while (!ov32[d] && lat < 64) begin
          @(negedge clk);
          lat++;
        end
        if (!ov32[d]) to = 1'b1;
        n_vec++;
        if (to || lat !== want_lat || {s32[d], co32[d], of32[d]} !== {es, ec, eo}) begin
          n_err++;
          $display("FAIL sweep[W%0d][%0d] a=%h b=%h k=%b: got s=%h c=%b o=%b lat=%0d want s=%h c=%b o=%b lat=%0d",
                   d, i, ra, rb, rk, s32[d], co32[d], of32[d], lat, es, ec, eo, want_lat);
        end
        or32[d] = 1'b1;
        @(negedge clk);
        or32[d] = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random8();
    test_back_to_back();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
